psg_bus_master: RTL and testbench
=================================

# psg_bus_master

Bus initiator that drives the AY-3-891x PSG register interface (bdir/bc1, with bc2 tied high) from a simple valid/ready request port. It queues register writes and reads, sequences the address-latch, data-write and data-read bus phases on the PSG clock enable, and returns read data. It sits between the host CPU decode logic and the `psg` instance, so the host never drives PSG bus timing directly.

## Interface
- `DEPTH`, 4: request FIFO depth; must be a power of two, at least 2.
- `ADDRMASK`, 4'b0000: upper address nibble driven during address latch; must match the PSG's address mask.
- `ADDR_CACHE`, 1: when 1, the latch phase is skipped if the register address equals the last latched address.
- `clock` in 1: single system clock; all logic is on posedge.
- `reset` in 1: asynchronous, active-low.
- `ce` in 1: PSG clock enable, the same signal the PSG receives.
- `req_valid` in 1: request present.
- `req_ready` out 1: FIFO not full.
- `req_we` in 1: 1 = write, 0 = read.
- `req_addr` in 4: PSG register number (0–15).
- `req_wdata` in 8: write data.
- `rd_valid` out 1: one-clock pulse when `rd_data` is updated.
- `rd_data` out 8: last read result, held until the next read completes.
- `busy` out 1: FIFO non-empty or a transaction is in progress.
- `bdir` out 1: to PSG bdir.
- `bc1` out 1: to PSG bc1.
- `da` out 8: to PSG d.
- `psg_q` in 8: from PSG q.

## Operation
- A request is accepted on any clock edge where `req_valid && req_ready`. Acceptance is not gated by `ce`. Each FIFO entry stores {we, addr, wdata}.
- `req_ready = !full`. A push while full is ignored, even if a pop happens on the same edge.
- A push to an empty FIFO while the FSM is in IDLE becomes visible to the FSM on the next `ce`.
- FSM state changes happen only on edges where `ce` is high. Bus outputs are registered, so each phase is held for exactly one `ce` period. The PSG samples the phase at the following `ce` edge.
- FSM states:
  - IDLE: bus 00, `da` = 0. If the FIFO is non-empty, pop one entry.
    - Go to LATCH, unless `ADDR_CACHE` is set, the cache is valid and addr equals the cached address.
    - Otherwise go directly to WRITE (we = 1) or READ (we = 0).
  - LATCH: bus 11, `da = {ADDRMASK, addr}`. Cache ← addr and mark it valid. Go to GAP.
  - GAP: bus 00. Go to WRITE or READ.
  - WRITE: bus 10, `da` = wdata. Go to END.
  - READ: bus 01, `da` = 0. At the `ce` edge that ends this phase, capture `rd_data ← psg_q` and pulse `rd_valid` for one clock. Go to END.
  - END: bus 00. Go to IDLE.
- END is always inserted. Back-to-back writes to register 13 therefore each produce a separate rising edge of the PSG write strobe, which restarts the envelope each time.
- Requests complete strictly in FIFO order. Reads and writes are never reordered.
- The address cache is invalidated on reset only.
- Asserting `reset` at any point has immediate effect: bus goes to 00, FIFO is emptied, the transaction in flight is dropped, and `rd_valid` is not pulsed.

## Timing
- Reset values: `bdir` = 0, `bc1` = 0, `da` = 0, `rd_data` = 0, `rd_valid` = 0, `req_ready` = 1, `busy` = 0, cache invalid.
- Write with latch: 4 `ce` periods (LATCH, GAP, WRITE, END) plus 1 `ce` in IDLE to pop.
- Cached write: WRITE + END plus the IDLE pop, 3 `ce` periods total.
- Reads have the same phase counts. `rd_valid` is asserted in the clock after the `ce` edge that closes READ.
- `busy` rises in the clock after acceptance. It falls in the clock after the END→IDLE edge, and only if the FIFO is empty.
- With `ce` held permanently high, the FSM advances every clock.
- FIFO pointers are log2(`DEPTH`) bits wide and wrap modulo `DEPTH`. The count is log2(`DEPTH`)+1 bits.

## Structure
- Shared package `psg_pkg` holds:
  - bus phase constants: IDLE 00, RD 01, WR 10, LATCH 11 (encoded as {bdir, bc1});
  - the FSM state enum;
  - the default `ADDRMASK`.
- One sub-module, `psg_bus_fifo`: a synchronous FIFO parameterised by width and depth, with push/pop/full/empty and async active-low reset.
- The FSM, address cache and read capture live in the top level.

## Test plan
- Write reg 0 = 0x5A, `ce` every 2nd clock → bus sequence 11/`da` = 0x00, then 00, then 10/`da` = 0x5A, then 00; each phase lasts 2 clocks; the PSG model holds a_period[7:0] = 0x5A.
- Write reg 1 = 0x0F, then read reg 1 with `ADDR_CACHE` = 1 → the read skips LATCH; `rd_valid` pulses once with `rd_data` = 0x0F.
- Queue 4 writes with `DEPTH` = 4 and `ce` stalled low → `req_ready` = 0 after the 4th push; a 5th push is ignored; after `ce` resumes, all 4 complete in order.
- Two writes to reg 13 back-to-back (0x08, then 0x0E) → END separates the two WRITE phases, and the PSG sees two strobe rising edges (envelope restarts twice).
- Reset asserted during a WRITE phase → `bdir`/`bc1` go to 00 immediately, FIFO is empty, `busy` = 0; the next request performs LATCH (cache invalid).
- Read reg 14 with PSG ioad = 0xC3 and R7 bit 6 = 0 → `rd_data` = 0xC3, `rd_valid` is high for exactly 1 clock.

Source files
------------

// File: rtl/psg_pkg.sv
// Shared definitions for the AY-3-891x PSG bus master: bus phase encodings,
// FSM states and the queued request format.
package psg_pkg;

    // Bus phases encoded as {bdir, bc1}; bc2 is tied high at the PSG.
    localparam logic [1:0] BusIdle  = 2'b00;
    localparam logic [1:0] BusRd    = 2'b01;
    localparam logic [1:0] BusWr    = 2'b10;
    localparam logic [1:0] BusLatch = 2'b11;

    localparam logic [3:0] DefaultAddrMask = 4'b0000;

    typedef enum logic [2:0] {
        StIdle,
        StLatch,
        StGap,
        StWrite,
        StRead,
        StEnd
    } psg_state_e;

    typedef struct packed {
        logic       we;
        logic [3:0] addr;
        logic [7:0] wdata;
    } psg_req_t;

    localparam int unsigned ReqWidth = $bits(psg_req_t);

endpackage

// File: rtl/psg_bus_fifo.sv
// Synchronous request FIFO. Pushes while full are dropped even when a pop
// happens on the same edge.
module psg_bus_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam logic [PtrW:0] DepthCnt = DEPTH[PtrW:0];

    logic [PtrW-1:0]  wptr_q, rptr_q;
    logic [PtrW:0]    count_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push, do_pop;

    assign full_o  = (count_q == DepthCnt);
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign rdata_o = mem_q[rptr_q];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + 1'b1;
            if (do_pop)  rptr_q <= rptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem_q[wptr_q] <= wdata_i;
    end

endmodule

// File: rtl/psg_bus_master.sv
// Valid/ready front end that queues PSG register accesses and sequences the
// latch, write and read bus phases on the PSG clock enable.
module psg_bus_master
    import psg_pkg::*;
#(
    parameter int unsigned DEPTH      = 4,
    parameter logic [3:0]  ADDRMASK   = DefaultAddrMask,
    parameter bit          ADDR_CACHE = 1'b1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ce,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_we,
    input  logic [3:0] req_addr,
    input  logic [7:0] req_wdata,
    output logic       rd_valid,
    output logic [7:0] rd_data,
    output logic       busy,
    output logic       bdir,
    output logic       bc1,
    output logic [7:0] da,
    input  logic [7:0] psg_q
);

    psg_state_e state_q, state_d;
    psg_req_t   push_req, head, cur_q;
    logic       full, empty, pop, cache_hit;
    logic       cache_valid_q;
    logic [3:0] cache_addr_q;
    logic       rd_valid_q;
    logic [7:0] rd_data_q;
    logic [1:0] bus;

    assign push_req = '{we: req_we, addr: req_addr, wdata: req_wdata};

    psg_bus_fifo #(
        .WIDTH (ReqWidth),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .push_i  (req_valid),
        .wdata_i (push_req),
        .pop_i   (pop),
        .rdata_o (head),
        .full_o  (full),
        .empty_o (empty)
    );

    assign req_ready = !full;
    assign busy      = !empty || (state_q != StIdle);
    assign pop       = ce && (state_q == StIdle) && !empty;
    assign cache_hit = ADDR_CACHE && cache_valid_q && (head.addr == cache_addr_q);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (ce) begin
            case (state_q)
                StIdle: begin
                    if (!empty) begin
                        if (cache_hit) state_d = head.we ? StWrite : StRead;
                        else           state_d = StLatch;
                    end
                end
                StLatch: state_d = StGap;
                StGap:   state_d = cur_q.we ? StWrite : StRead;
                StWrite: state_d = StEnd;
                StRead:  state_d = StEnd;
                StEnd:   state_d = StIdle;
                default: state_d = StIdle;
            endcase
        end
    end

    always_comb begin
        bus = BusIdle;
        da  = 8'h00;
        case (state_q)
            StLatch: begin
                bus = BusLatch;
                da  = {ADDRMASK, cur_q.addr};
            end
            StWrite: begin
                bus = BusWr;
                da  = cur_q.wdata;
            end
            StRead:  bus = BusRd;
            default: bus = BusIdle;
        endcase
    end

    assign {bdir, bc1} = bus;

    // Current transaction, address cache and read capture.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cur_q         <= '0;
            cache_valid_q <= 1'b0;
            cache_addr_q  <= 4'h0;
            rd_valid_q    <= 1'b0;
            rd_data_q     <= 8'h00;
        end else begin
            if (pop) cur_q <= head;
            if (ce && (state_q == StLatch)) begin
                cache_valid_q <= 1'b1;
                cache_addr_q  <= cur_q.addr;
            end
            rd_valid_q <= ce && (state_q == StRead);
            if (ce && (state_q == StRead)) rd_data_q <= psg_q;
        end
    end

    assign rd_valid = rd_valid_q;
    assign rd_data  = rd_data_q;

endmodule

// File: tb/tb_psg_bus_master.sv
// Directed bench for psg_bus_master with a minimal PSG register model on the bus.
module tb_psg_bus_master;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       ce = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic       req_we = 1'b0;
    logic [3:0] req_addr = 4'h0;
    logic [7:0] req_wdata = 8'h00;
    logic       rd_valid;
    logic [7:0] rd_data;
    logic       busy;
    logic       bdir, bc1;
    logic [7:0] da;
    logic [7:0] psg_q;
    logic [1:0] bus;

    psg_bus_master #(
        .DEPTH      (4),
        .ADDRMASK   (4'b0000),
        .ADDR_CACHE (1'b1)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .ce        (ce),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data),
        .busy      (busy),
        .bdir      (bdir),
        .bc1       (bc1),
        .da        (da),
        .psg_q     (psg_q)
    );

    always #5 clock = ~clock;
    assign bus = {bdir, bc1};

    // 0: ce stalled low, 1: ce always high, 2: ce every second clock.
    int ce_mode = 1;
    always @(negedge clock) begin
        if (ce_mode == 2) ce <= ~ce;
        else              ce <= (ce_mode == 1);
    end

    // PSG register model: samples the bus phase on each ce edge.
    logic [7:0] m_regs [16] = '{default: 8'h00};
    logic [3:0] m_addr = 4'h0;
    logic [1:0] prev_bus = 2'b00;
    logic [7:0] ioad = 8'hC3;
    int         wlog [64] = '{default: 0};
    int         wcnt = 0;
    int         latch_clks = 0;
    int         strobes = 0;

    assign psg_q = (m_addr == 4'd14 && !m_regs[7][6]) ? ioad : m_regs[m_addr];

    always @(posedge clock) begin
        prev_bus <= bus;
        if (ce) begin
            if (bus == 2'b11) m_addr <= da[3:0];
            if (bus == 2'b10) begin
                m_regs[m_addr]  <= da;
                wlog[wcnt % 64] <= int'(m_addr);
                wcnt            <= wcnt + 1;
            end
        end
        if (bus == 2'b11) latch_clks <= latch_clks + 1;
        if (bus == 2'b10 && prev_bus != 2'b10 && m_addr == 4'd13) strobes <= strobes + 1;
    end

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;
    int n, rv, la, w0, st;
    logic found;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic push(input logic we, input logic [3:0] a, input logic [7:0] d);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = a;
        req_wdata = d;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic wait_bus(input logic [1:0] b, input int limit, input string tag);
        int k;
        k = 0;
        while (bus !== b && k < limit) begin
            tick();
            k++;
        end
        check(tag, (bus === b), 1);
    endtask

    task automatic run_len(output int len);
        logic [1:0] v;
        v   = bus;
        len = 0;
        while (bus === v && len < 20) begin
            tick();
            len++;
        end
    endtask

    task automatic wait_idle(input int limit, input string tag);
        int k;
        k = 0;
        while (busy && k < limit) begin
            tick();
            k++;
        end
        check(tag, busy, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values
        repeat (3) @(posedge clock);
        #1;
        check("rst_bdir", bdir, 0);
        check("rst_bc1", bc1, 0);
        check("rst_da", da, 8'h00);
        check("rst_rd_data", rd_data, 8'h00);
        check("rst_rd_valid", rd_valid, 0);
        check("rst_req_ready", req_ready, 1);
        check("rst_busy", busy, 0);
        reset = 1'b1;
        tick();

        // Write reg 0 = 0x5A with ce every second clock: each phase lasts 2 clocks
        ce_mode = 2;
        tick();
        push(1'b1, 4'd0, 8'h5A);
        check("t1_busy_rise", busy, 1);
        wait_bus(2'b11, 20, "t1_latch_seen");
        check("t1_latch_da", da, 8'h00);
        run_len(n);
        check("t1_latch_len", n, 2);
        check("t1_gap_bus", bus, 2'b00);
        run_len(n);
        check("t1_gap_len", n, 2);
        check("t1_write_bus", bus, 2'b10);
        check("t1_write_da", da, 8'h5A);
        run_len(n);
        check("t1_write_len", n, 2);
        n = 0;
        while (busy && n < 20) begin
            tick();
            n++;
        end
        check("t1_end_len", n, 2);
        check("t1_psg_reg0", m_regs[0], 8'h5A);

        // Write reg 1 then cached read of reg 1
        ce_mode = 1;
        tick();
        la = latch_clks;
        push(1'b1, 4'd1, 8'h0F);
        push(1'b0, 4'd1, 8'h00);
        n  = 0;
        rv = 0;
        while (busy && n < 40) begin
            if (rd_valid) rv++;
            tick();
            n++;
        end
        check("t2_idle", busy, 0);
        check("t2_latch_count", latch_clks - la, 1);
        check("t2_rd_valid_clks", rv, 1);
        check("t2_rd_data", rd_data, 8'h0F);

        // Fill the FIFO with ce stalled; 5th push must be dropped
        ce_mode = 0;
        tick();
        tick();
        push(1'b1, 4'd2, 8'h11);
        push(1'b1, 4'd3, 8'h22);
        push(1'b1, 4'd4, 8'h33);
        check("t3_ready_before_full", req_ready, 1);
        push(1'b1, 4'd5, 8'h44);
        check("t3_ready_full", req_ready, 0);
        check("t3_busy", busy, 1);
        push(1'b1, 4'd6, 8'h55);
        check("t3_ready_still_full", req_ready, 0);
        w0 = wcnt;
        ce_mode = 1;
        wait_idle(80, "t3_idle");
        check("t3_write_count", wcnt - w0, 4);
        for (int i = 0; i < 4; i++) check("t3_order", wlog[(w0 + i) % 64], 2 + i);
        check("t3_reg5", m_regs[5], 8'h44);
        check("t3_reg6_untouched", m_regs[6], 8'h00);

        // Back-to-back writes to reg 13: two separate strobes
        st = strobes;
        la = latch_clks;
        push(1'b1, 4'd13, 8'h08);
        push(1'b1, 4'd13, 8'h0E);
        wait_idle(40, "t4_idle");
        check("t4_strobes", strobes - st, 2);
        check("t4_latch_count", latch_clks - la, 1);
        check("t4_reg13", m_regs[13], 8'h0E);

        // Reset during a cached WRITE phase
        push(1'b1, 4'd13, 8'h77);
        wait_bus(2'b10, 20, "t5_write_seen");
        #2;
        reset = 1'b0;
        #1;
        check("t5_bus_async", bus, 2'b00);
        check("t5_da_async", da, 8'h00);
        check("t5_busy_async", busy, 0);
        check("t5_ready_async", req_ready, 1);
        check("t5_rd_data_rst", rd_data, 8'h00);
        @(negedge clock);
        reset = 1'b1;
        tick();
        check("t5_rd_valid", rd_valid, 0);
        check("t5_reg13_kept", m_regs[13], 8'h0E);
        la = latch_clks;
        push(1'b1, 4'd13, 8'h66);
        wait_idle(40, "t5_idle");
        check("t5_relatch", latch_clks - la, 1);
        check("t5_reg13_new", m_regs[13], 8'h66);

        // Read reg 14 (IO port A in input mode)
        push(1'b0, 4'd14, 8'h00);
        n = 0;
        while (!rd_valid && n < 30) begin
            tick();
            n++;
        end
        found = rd_valid;
        check("t6_rd_valid_seen", found, 1);
        check("t6_rd_data", rd_data, 8'hC3);
        tick();
        check("t6_rd_valid_single", rd_valid, 0);
        wait_idle(20, "t6_idle");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
